// File: rtl/instr_enc.sv
// Sequential instruction encoder: validates one field bundle per handshake, packs it
// into the 16-bit IR format and writes it to instruction memory at an auto-incrementing address.
module instr_enc #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_opcode,
    input  logic [1:0]        in_op,
    input  logic [2:0]        in_rn,
    input  logic [2:0]        in_rd,
    input  logic [2:0]        in_rm,
    input  logic [1:0]        in_shift,
    input  logic [7:0]        in_imm,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ERR   = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    function automatic logic op_legal(input logic [2:0] opc, input logic [1:0] op);
        logic ok;
        case ({opc, op})
            5'b110_10, 5'b110_00, 5'b101_00, 5'b101_01, 5'b101_10, 5'b101_11,
            5'b011_00, 5'b100_00, 5'b111_00: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Only the load/store offset is narrowed to 5 bits, so only it can overflow.
    function automatic logic imm_in_range(input logic [2:0] opc, input logic [7:0] imm);
        logic ok;
        case (opc)
            3'b011, 3'b100: ok = (imm[7:5] == {3{imm[4]}});
            default:        ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [15:0] encode(input logic [2:0] opc, input logic [1:0] op,
                                           input logic [2:0] rn, input logic [2:0] rd,
                                           input logic [1:0] sh, input logic [2:0] rm,
                                           input logic [7:0] imm);
        logic [15:0] w;
        case ({opc, op})
            5'b110_10:            w = {opc, op, rn, imm};
            5'b110_00, 5'b101_11: w = {opc, op, 3'b000, rd, sh, rm};
            5'b101_01:            w = {opc, op, rn, 3'b000, sh, rm};
            5'b101_00, 5'b101_10: w = {opc, op, rn, rd, sh, rm};
            5'b011_00, 5'b100_00: w = {opc, op, rn, rd, imm[4:0]};
            5'b111_00:            w = 16'hE000;
            default:              w = 16'h0000;
        endcase
        return w;
    endfunction

    state_t              state_r;
    state_t              state_next_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W:0]     count_r;
    logic [15:0]         din_r;
    logic [1:0]          code_r;
    logic                halt_r;
    logic                done_r;
    logic                full_r;
    logic                accept_s;
    logic                op_ok_s;
    logic                bundle_ok_s;
    logic [1:0]          bundle_code_s;
    logic [15:0]         word_s;

    assign accept_s      = in_valid & in_ready;
    assign op_ok_s       = op_legal(in_opcode, in_op);
    assign bundle_ok_s   = op_ok_s & imm_in_range(in_opcode, in_imm);
    assign bundle_code_s = op_ok_s ? 2'b10 : 2'b01;
    assign word_s        = encode(in_opcode, in_op, in_rn, in_rd, in_shift, in_rm, in_imm);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = bundle_ok_s ? WRITE : ERR;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (clear) begin
                    state_next_s = IDLE;
                end else if (halt_r || (addr_r == ADDR_MAX)) begin
                    state_next_s = STOP;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ERR:     state_next_s = IDLE;
            STOP:    state_next_s = clear ? IDLE : STOP;
            default: state_next_s = IDLE;
        endcase
    end

    // Handshake and strobe decode; the write strobe is killed while reset is high.
    always_comb begin
        in_ready  = 1'b0;
        mem_write = 1'b0;
        err       = 1'b0;
        case (state_r)
            IDLE:    in_ready  = ~clear;
            WRITE:   mem_write = ~reset;
            ERR:     err       = 1'b1;
            default: in_ready  = 1'b0;
        endcase
    end

    // Captured word, error code, address/count and sticky done/full flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            din_r   <= 16'h0000;
            code_r  <= 2'b00;
            halt_r  <= 1'b0;
            addr_r  <= '0;
            count_r <= '0;
            done_r  <= 1'b0;
            full_r  <= 1'b0;
        end else begin
            if (accept_s && bundle_ok_s) begin
                din_r  <= word_s;
                halt_r <= (in_opcode == 3'b111);
            end
            if (accept_s && !bundle_ok_s) begin
                code_r <= bundle_code_s;
            end
            if (state_r == WRITE) begin
                // A clear that lands on the write lets the write finish but restarts the program.
                if (clear) begin
                    addr_r  <= '0;
                    count_r <= '0;
                end else begin
                    addr_r  <= addr_r + ADDR_W'(1);
                    count_r <= count_r + (ADDR_W + 1)'(1);
                    if (halt_r) begin
                        done_r <= 1'b1;
                    end else if (addr_r == ADDR_MAX) begin
                        full_r <= 1'b1;
                    end
                end
            end else if (clear) begin
                addr_r  <= '0;
                count_r <= '0;
                done_r  <= 1'b0;
                full_r  <= 1'b0;
            end
        end
    end

    assign mem_addr = addr_r;
    assign mem_din  = din_r;
    assign err_code = code_r;
    assign done     = done_r;
    assign full     = full_r;
    assign count    = count_r;

endmodule

// File: tb/tb_instr_enc.sv
// Bench for instr_enc: two instances (ADDR_W=8 and ADDR_W=2) on shared stimulus, checked each
// cycle against a transaction-level model, plus hand-computed expectations on key cycles.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_opcode = 3'd0;
    logic [1:0]  in_op = 2'd0;
    logic [2:0]  in_rn = 3'd0;
    logic [2:0]  in_rd = 3'd0;
    logic [2:0]  in_rm = 3'd0;
    logic [1:0]  in_shift = 2'd0;
    logic [7:0]  in_imm = 8'd0;

    logic        r8, w8, e8, dn8, f8;
    logic [7:0]  a8;
    logic [15:0] d8;
    logic [1:0]  c8;
    logic [8:0]  n8;
    logic        r2, w2, e2, dn2, f2;
    logic [1:0]  a2;
    logic [15:0] d2;
    logic [1:0]  c2;
    logic [2:0]  n2;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    instr_enc #(.ADDR_W(8)) dut8 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(r8),
        .in_opcode(in_opcode), .in_op(in_op), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_shift(in_shift), .in_imm(in_imm), .mem_write(w8), .mem_addr(a8), .mem_din(d8),
        .err(e8), .err_code(c8), .done(dn8), .full(f8), .count(n8)
    );

    instr_enc #(.ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(r2),
        .in_opcode(in_opcode), .in_op(in_op), .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm),
        .in_shift(in_shift), .in_imm(in_imm), .mem_write(w2), .mem_addr(a2), .mem_din(d2),
        .err(e2), .err_code(c2), .done(dn2), .full(f2), .count(n2)
    );

    always #5 clk = ~clk;

    // Model: one pending outcome (0 none, 1 write, 2 reject) per instance plus program counters.
    int          cap [2] = '{256, 4};
    int          m_pend [2];
    int          m_addr [2];
    int          m_count [2];
    bit          m_done [2];
    bit          m_full [2];
    bit          m_halt [2];
    logic [15:0] m_din [2];
    logic [1:0]  m_code [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_word(output bit ok, output logic [1:0] code, output logic [15:0] w);
        logic [15:0] all_fields;
        all_fields = {in_opcode, in_op, in_rn, in_rd, in_shift, in_rm};
        ok = 1'b1;
        code = 2'b00;
        w = 16'h0000;
        if (in_opcode == 3'd6 && in_op == 2'd2)      w = {in_opcode, in_op, in_rn, in_imm};
        else if (in_opcode == 3'd6 && in_op == 2'd0) w = all_fields & 16'hF8FF;
        else if (in_opcode == 3'd5 && in_op == 2'd1) w = all_fields & 16'hFF1F;
        else if (in_opcode == 3'd5 && in_op == 2'd3) w = all_fields & 16'hF8FF;
        else if (in_opcode == 3'd5)                  w = all_fields;
        else if ((in_opcode == 3'd3 || in_opcode == 3'd4) && in_op == 2'd0) begin
            w = {in_opcode, in_op, in_rn, in_rd, in_imm[4:0]};
            if ($signed(in_imm) < -16 || $signed(in_imm) > 15) begin
                ok = 1'b0;
                code = 2'b10;
            end
        end
        else if (in_opcode == 3'd7 && in_op == 2'd0) w = 16'hE000;
        else begin
            ok = 1'b0;
            code = 2'b01;
        end
    endtask

    function automatic bit m_ready(input int i);
        return (m_pend[i] == 0) && !m_done[i] && !m_full[i] && !clear;
    endfunction

    task automatic model_step();
        bit ok;
        bit rdy;
        logic [1:0] cd;
        logic [15:0] w;
        for (int i = 0; i < 2; i++) begin
            rdy = m_ready(i);
            if (reset) begin
                m_pend[i] = 0; m_addr[i] = 0; m_count[i] = 0; m_done[i] = 0;
                m_full[i] = 0; m_halt[i] = 0; m_din[i] = 16'h0000; m_code[i] = 2'b00;
            end else begin
                if (m_pend[i] == 1) begin
                    if (clear) begin
                        m_addr[i] = 0;
                        m_count[i] = 0;
                    end else begin
                        m_count[i]++;
                        if (m_halt[i]) m_done[i] = 1;
                        else if (m_addr[i] == cap[i] - 1) m_full[i] = 1;
                        m_addr[i] = (m_addr[i] + 1) % cap[i];
                    end
                end else if (clear) begin
                    m_addr[i] = 0; m_count[i] = 0; m_done[i] = 0; m_full[i] = 0;
                end
                m_pend[i] = 0;
                if (rdy && in_valid) begin
                    model_word(ok, cd, w);
                    if (ok) begin
                        m_pend[i] = 1;
                        m_din[i] = w;
                        m_halt[i] = (in_opcode == 3'd7);
                    end else begin
                        m_pend[i] = 2;
                        m_code[i] = cd;
                    end
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("ready8", r8, m_ready(0));
                chk("write8", w8, (m_pend[0] == 1) && !reset);
                chk("addr8", a8, m_addr[0]);
                chk("din8", d8, m_din[0]);
                chk("err8", e8, m_pend[0] == 2);
                chk("code8", c8, m_code[0]);
                chk("done8", dn8, m_done[0]);
                chk("full8", f8, m_full[0]);
                chk("count8", n8, m_count[0]);
                chk("ready2", r2, m_ready(1));
                chk("write2", w2, (m_pend[1] == 1) && !reset);
                chk("addr2", a2, m_addr[1]);
                chk("din2", d2, m_din[1]);
                chk("err2", e2, m_pend[1] == 2);
                chk("code2", c2, m_code[1]);
                chk("done2", dn2, m_done[1]);
                chk("full2", f2, m_full[1]);
                chk("count2", n2, m_count[1]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [2:0] oc, input logic [1:0] op, input logic [2:0] rn,
                         input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm,
                         input logic [7:0] imm);
        in_opcode = oc; in_op = op; in_rn = rn; in_rd = rd;
        in_shift = sh; in_rm = rm; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Presents a bundle for one edge; returns 2 time units into the write/err cycle.
    task automatic send(input logic [2:0] oc, input logic [1:0] op, input logic [2:0] rn,
                        input logic [2:0] rd, input logic [1:0] sh, input logic [2:0] rm,
                        input logic [7:0] imm);
        drive(oc, op, rn, rd, sh, rm, imm);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        tick();
        chk_on = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", r8, 1); chk("rst_write", w8, 0); chk("rst_count", n8, 0);
        chk("rst_din", d8, 16'h0000); chk("rst_code", c8, 0);
        tick();

        send(3'd6, 2'd2, 3'd0, 3'd0, 2'd0, 3'd0, 8'h07);
        @(negedge clk);
        chk("mov_write", w8, 1); chk("mov_addr", a8, 0); chk("mov_din", d8, 16'hD007);
        tick();
        @(negedge clk);
        chk("mov_count", n8, 1);
        tick();

        send(3'd5, 2'd0, 3'd1, 3'd2, 2'd1, 3'd0, 8'h00);
        @(negedge clk);
        chk("add_din", d8, 16'hA148); chk("add_addr", a8, 1);
        tick();
        send(3'd5, 2'd3, 3'd5, 3'd3, 2'd0, 3'd4, 8'h00);
        @(negedge clk);
        chk("mvn_din", d8, 16'hB864); chk("mvn_addr", a8, 2);
        tick();

        send(3'd3, 2'd0, 3'd1, 3'd3, 2'd0, 3'd0, 8'hFE);
        @(negedge clk);
        chk("ldr_din", d8, 16'h617E); chk("ldr_addr", a8, 3);
        tick();
        send(3'd3, 2'd0, 3'd1, 3'd3, 2'd0, 3'd0, 8'h10);
        @(negedge clk);
        chk("range_err", e8, 1); chk("range_code", c8, 2); chk("range_nowr", w8, 0);
        tick();
        send(3'd6, 2'd2, 3'd1, 3'd0, 2'd0, 3'd0, 8'h01);
        @(negedge clk);
        chk("reuse_addr", a8, 4); chk("reuse_write", w8, 1);
        tick();

        send(3'd0, 2'd0, 3'd0, 3'd0, 2'd0, 3'd0, 8'h00);
        @(negedge clk);
        chk("ill_err", e8, 1); chk("ill_code", c8, 1);
        tick();
        send(3'd3, 2'd1, 3'd1, 3'd1, 2'd0, 3'd1, 8'h10);
        @(negedge clk);
        chk("both_code", c8, 1);
        tick();

        send(3'd7, 2'd0, 3'd7, 3'd7, 2'd3, 3'd7, 8'hFF);
        @(negedge clk);
        chk("halt_din", d8, 16'hE000); chk("halt_write", w8, 1);
        tick();
        @(negedge clk);
        chk("halt_done", dn8, 1); chk("halt_ready", r8, 0); chk("halt_count", n8, 6);
        tick();
        drive(3'd6, 2'd2, 3'd2, 3'd0, 2'd0, 3'd0, 8'h55);
        repeat (4) tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("stop_count", n8, 6); chk("stop_addr", a8, 6);
        tick();

        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clr_done", dn8, 0); chk("clr_count", n8, 0); chk("clr_ready", r8, 1);
        tick();

        drive(3'd6, 2'd2, 3'd3, 3'd0, 2'd0, 3'd0, 8'h80);
        repeat (7) tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("fill_full", f2, 1); chk("fill_count", n2, 4); chk("fill_ready", r2, 0);
        chk("fill_full8", f8, 0); chk("fill_count8", n8, 4);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("refill_count", n2, 0); chk("refill_full", f2, 0);
        tick();
        send(3'd6, 2'd2, 3'd0, 3'd0, 2'd0, 3'd0, 8'h01);
        @(negedge clk);
        chk("refill_addr", a2, 0); chk("refill_write", w2, 1);
        tick();

        send(3'd6, 2'd2, 3'd4, 3'd0, 2'd0, 3'd0, 8'h22);
        clear = 1'b1;
        @(negedge clk);
        chk("clrwr_write", w8, 1);
        tick();
        clear = 1'b0;
        @(negedge clk);
        chk("clrwr_count", n8, 0); chk("clrwr_ready", r8, 1);
        tick();

        send(3'd6, 2'd2, 3'd5, 3'd0, 2'd0, 3'd0, 8'h33);
        reset = 1'b1;
        @(negedge clk);
        chk("rstwr_write", w8, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rstwr_count", n8, 0); chk("rstwr_ready", r8, 1); chk("rstwr_addr", a8, 0);
        tick();

        send(3'd6, 2'd0, 3'd7, 3'd6, 2'd2, 3'd5, 8'h00);
        @(negedge clk);
        chk("movreg_din", d8, 16'hC0D5);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_enc.md
# instr_enc

Sequential instruction encoder for the simple RISC machine. It accepts one assembly-level instruction per handshake as separate fields (opcode, op, register numbers, shift, immediate), and performs legality and immediate-range checks. It then packs the fields into the 16-bit IR format consumed by the instruction decoder and writes the word into instruction memory at an auto-incrementing address. It sits between a program loader or test harness and the instruction RAM write port.

## Interface
- ADDR_W, default 8: instruction memory address width; capacity is 2^ADDR_W words.

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  restart program: address and count to 0, clears done/full
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept a bundle this cycle
- in_opcode  in  3  instruction class
- in_op  in  2  sub-operation
- in_rn, in_rd, in_rm  in  3 each  register numbers
- in_shift  in  2  shift code
- in_imm  in  8  immediate, two's complement
- mem_write  out  1  one-cycle write strobe
- mem_addr  out  ADDR_W  write address
- mem_din  out  16  encoded instruction
- err  out  1  one-cycle pulse: bundle rejected
- err_code  out  2  01 illegal opcode/op, 10 immediate out of range; held until next err
- done  out  1  HALT written; sticky until clear/reset
- full  out  1  memory full; sticky until clear/reset
- count  out  ADDR_W+1  words written since reset/clear

## Operation
- States: IDLE, WRITE, ERR, STOP. STOP is entered when done or full is set.
- in_ready = 1 only in IDLE with clear=0. Accept = in_valid & in_ready; fields are registered on accept.
- Legal (opcode, op) pairs and encodings. Bracketed fields are forced to 0 regardless of the inputs.
  - 110,10 MOV imm: 110 10 rn imm[7:0]
  - 110,00 MOV reg: 110 00 [000] rd shift rm
  - 101,00 ADD: 101 00 rn rd shift rm
  - 101,01 CMP: 101 01 rn [000] shift rm
  - 101,10 AND: 101 10 rn rd shift rm
  - 101,11 MVN: 101 11 [000] rd shift rm
  - 011,00 LDR: 011 00 rn rd imm[4:0]
  - 100,00 STR: 100 00 rn rd imm[4:0]
  - 111,00 HALT: 111 00 [00000000000]
- Any other pair is rejected with err_code 01.
- LDR/STR range check: imm[7:5] must all equal imm[4] (signed −16..15); otherwise reject with err_code 10. If both the opcode/op check and the range check fail, 01 takes precedence.
- Accept of a legal bundle → WRITE. Accept of an illegal bundle → ERR.
- WRITE:
  - Drives mem_write=1, mem_addr=addr, mem_din=word.
  - Then addr += 1 and count += 1.
  - If the word was HALT, done=1 → STOP.
  - Else if addr was 2^ADDR_W−1, full=1 and addr wraps to 0 → STOP.
  - Else → IDLE.
- ERR: err=1 and err_code updated; no write; addr and count unchanged → IDLE.
- STOP: in_ready=0 until clear.
- clear:
  - In IDLE/ERR/STOP: addr=0, count=0, done=0, full=0; next state IDLE.
  - In WRITE: the write completes first; the counters then load 0 rather than incrementing, and done/full stay 0. Next state is IDLE.
- Reset values: state IDLE, in_ready=1 (after reset is released), mem_write=0, mem_addr=0, mem_din=0, err=0, err_code=00, done=0, full=0, count=0.
- mem_write is gated to 0 in any cycle where reset=1, so a write in progress is abandoned.

## Timing
- Accept in cycle N → mem_write (or err) in cycle N+1 → in_ready again in N+2 unless STOP. Maximum throughput is one instruction per 2 cycles.
- mem_addr and mem_din are stable for the whole mem_write cycle. mem_din holds its last value otherwise.
- done/full assert in cycle N+2, i.e. the cycle after the final write.
- in_valid may be held high; bundles are taken only on cycles where in_ready is high.

## Test plan
- Reset, then MOV R0,#7 (110,10, rn=0, imm=0x07) → N+1: mem_write=1, mem_addr=0, mem_din=0xD007; count=1.
- ADD R2,R1,R0 LSL#1 (101,00, rn=1, rd=2, shift=01, rm=0), then MVN with rn=5, rd=3, shift=00, rm=4 → writes 0xA148, then 0xB864 (rn forced 0), at consecutive addresses.
- LDR R3,[R1,#-2] with imm=0xFE → 0x617E. LDR with imm=0x10 → err pulse, err_code=10, no mem_write, next write reuses the same address.
- Opcode 000, op 00 → err_code=01. HALT (111,00) with nonzero rn/rd → mem_din=0xE000, done=1, in_ready=0; a following in_valid is ignored until clear.
- ADDR_W=2: four MOV imm writes → addresses 0..3, full=1, count=4, in_ready=0. Then clear → count=0, full=0, next write at address 0.
- Reset asserted in the WRITE cycle → mem_write=0 that cycle; count=0, state IDLE next cycle.
